// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types for the hazard controller: shadow-stage entry,
// control mode encoding and the producer predicate.
package rv32i_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  ld;
    } shadow_entry_t;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_FREEZE = 2'd1,
        MODE_SQUASH = 2'd2,
        MODE_STALL  = 2'd3
    } ctrl_mode_t;

    // A stage only produces a value worth waiting for if it really writes a non-x0 register.
    function automatic logic is_producer(input shadow_entry_t e);
        return e.v & e.we & (e.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against one shadow-stage entry.
module hazard_match
    import rv32i_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rs_used,
    input  shadow_entry_t         entry,
    output logic                  hit
);

    assign hit = id_valid & rs_used & (rs != '0) & (rs == entry.rd) & is_producer(entry);

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard controller: shadow EX/MEM/WB tracking, RAW/load-use
// detection, branch squash and memory-wait freeze. Build option: HAZARD_FWD_EN.
//
// mode        | meaning
// MODE_RUN    | no hazard, shadow advances with the ID instruction
// MODE_FREEZE | load in MEM waiting on memory; EX/MEM hold, WB bubbles
// MODE_SQUASH | taken branch in EX; flush IF/ID, bubble ID/EX
// MODE_STALL  | RAW dependence; hold PC and IF/ID, bubble ID/EX
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_werf_enable,
    input  logic                  id_load,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_cycles
);

    shadow_entry_t ex_q, mem_q, wb_q;
    shadow_entry_t ex_d, mem_d, wb_d;
    shadow_entry_t id_entry;
    ctrl_mode_t    mode;

    logic hit_rs1_ex, hit_rs1_mem, hit_rs1_wb;
    logic hit_rs2_ex, hit_rs2_mem, hit_rs2_wb;
    logic freeze, raw;

    hazard_match u_rs1_ex  (.id_valid(id_valid), .rs(id_rs1), .rs_used(id_rs1_used), .entry(ex_q),  .hit(hit_rs1_ex));
    hazard_match u_rs1_mem (.id_valid(id_valid), .rs(id_rs1), .rs_used(id_rs1_used), .entry(mem_q), .hit(hit_rs1_mem));
    hazard_match u_rs1_wb  (.id_valid(id_valid), .rs(id_rs1), .rs_used(id_rs1_used), .entry(wb_q),  .hit(hit_rs1_wb));
    hazard_match u_rs2_ex  (.id_valid(id_valid), .rs(id_rs2), .rs_used(id_rs2_used), .entry(ex_q),  .hit(hit_rs2_ex));
    hazard_match u_rs2_mem (.id_valid(id_valid), .rs(id_rs2), .rs_used(id_rs2_used), .entry(mem_q), .hit(hit_rs2_mem));
    hazard_match u_rs2_wb  (.id_valid(id_valid), .rs(id_rs2), .rs_used(id_rs2_used), .entry(wb_q),  .hit(hit_rs2_wb));

    assign freeze = mem_q.v & mem_q.ld & ~mem_ready;

`ifdef HAZARD_FWD_EN
    // Forwarding covers everything except a load still in EX.
    assign raw = (hit_rs1_ex | hit_rs2_ex) & ex_q.ld;
`else
    // WB counts too: the register file write lands after the same-cycle read.
    assign raw = hit_rs1_ex | hit_rs1_mem | hit_rs1_wb |
                 hit_rs2_ex | hit_rs2_mem | hit_rs2_wb;
`endif

    assign id_entry = '{v: id_valid, rd: id_rd, we: id_werf_enable, ld: id_load};

    always_comb begin
        mode = MODE_RUN;
        if (freeze)
            mode = MODE_FREEZE;
        else if (branch_taken)
            mode = MODE_SQUASH;
        else if (raw)
            mode = MODE_STALL;
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        ex_d        = id_entry;
        mem_d       = ex_q;
        wb_d        = mem_q;
        case (mode)
            MODE_FREEZE: begin
                pipe_freeze = 1'b1;
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                ex_d        = ex_q;
                mem_d       = mem_q;
                wb_d        = '0;
            end
            MODE_SQUASH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                ex_d        = '0;
            end
            MODE_STALL: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                ex_d        = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // A freeze overlapping a branch is not counted; the branch returns after the freeze.
    logic cnt_inc;
    assign cnt_inc = (freeze | raw) & ~branch_taken & (stall_cycles != '1);

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (cnt_inc)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// against an instruction-level reference model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int unsigned SAT = (1 << CNT_W) - 1;

`ifdef HAZARD_FWD_EN
    localparam int EXP_B2B = 0;
    localparam int EXP_LU  = 1;
    localparam int EXP_HOLD_STALL = 0;
`else
    localparam int EXP_B2B = 3;
    localparam int EXP_LU  = 3;
    localparam int EXP_HOLD_STALL = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_rs1_used, id_rs2_used;
    logic             id_werf_enable, id_load;
    logic             branch_taken, mem_ready;
    logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
    logic [CNT_W-1:0] stall_cycles;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_werf_enable(id_werf_enable), .id_load(id_load),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .stall_cycles(stall_cycles)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: in-flight instructions by age (0 = one cycle past ID).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } inst_t;

    inst_t       pl[3];
    int unsigned m_cnt;
    bit          o_stall, o_freeze, o_flush, o_bubble;

    function automatic bit src_hits(input bit [4:0] rs, input bit used);
        if (!(id_valid && used && rs != 0)) return 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit writes_it;
            writes_it = pl[i].v && pl[i].we && pl[i].rd != 0 && pl[i].rd == rs;
`ifdef HAZARD_FWD_EN
            if (i == 0 && writes_it && pl[i].ld) return 1'b1;
`else
            if (writes_it) return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    task automatic step(input bit v, input bit [4:0] r1, input bit [4:0] r2,
                        input bit u1, input bit u2, input bit [4:0] rd,
                        input bit we, input bit ld, input bit bt, input bit mr,
                        input bit r);
        bit e_frz, e_raw;
        @(negedge clk);
        rst = r; id_valid = v; id_rs1 = r1; id_rs2 = r2;
        id_rs1_used = u1; id_rs2_used = u2; id_rd = rd;
        id_werf_enable = we; id_load = ld; branch_taken = bt; mem_ready = mr;
        #1;
        e_frz = pl[1].v && pl[1].ld && !mr;
        e_raw = src_hits(r1, u1) || src_hits(r2, u2);
        chk("pc_stall",     pc_stall,     e_frz || (!bt && e_raw));
        chk("ifid_stall",   ifid_stall,   e_frz || (!bt && e_raw));
        chk("ifid_flush",   ifid_flush,   !e_frz && bt);
        chk("idex_bubble",  idex_bubble,  !e_frz && (bt || e_raw));
        chk("pipe_freeze",  pipe_freeze,  e_frz);
        chk("stall_cycles", stall_cycles, m_cnt);
        o_stall = pc_stall; o_freeze = pipe_freeze;
        o_flush = ifid_flush; o_bubble = idex_bubble;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 3; i++) pl[i] = '{v: 0, rd: 0, we: 0, ld: 0};
            m_cnt = 0;
        end else begin
            if ((e_frz || e_raw) && !bt && m_cnt < SAT) m_cnt++;
            if (e_frz) begin
                pl[2] = '{v: 0, rd: 0, we: 0, ld: 0};
            end else begin
                pl[2] = pl[1];
                pl[1] = pl[0];
                if (bt || e_raw) pl[0] = '{v: 0, rd: 0, we: 0, ld: 0};
                else             pl[0] = '{v: v, rd: rd, we: we, ld: ld};
            end
        end
    endtask

    task automatic do_rst();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic nop(input bit mr);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, mr, 0);
    endtask

    task automatic issue(input bit [4:0] rd, input bit ld, input bit [4:0] r1, input bit [4:0] r2);
        step(1, r1, r2, 1, 1, rd, 1, ld, 0, 1, 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 3; i++) pl[i] = '{v: 0, rd: 0, we: 0, ld: 0};
        m_cnt = 0;
        rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_werf_enable = 0; id_load = 0; branch_taken = 0; mem_ready = 1;
        @(posedge clk);
        do_rst();

        // add x5 ; add x6,x5,x1
        issue(5, 0, 1, 2);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            issue(6, 0, 5, 1);
            if (!o_stall) break;
            cnt++;
        end
        chk("b2b_stall_len", cnt, EXP_B2B);
        #1 chk("b2b_stall_cycles", stall_cycles, EXP_B2B);

        // lw x7 ; add x8,x7,x7
        do_rst();
        issue(7, 1, 1, 2);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            issue(8, 0, 7, 7);
            if (!o_stall) break;
            cnt++;
        end
        chk("loaduse_stall_len", cnt, EXP_LU);

        // lw x7 then add x9; memory holds the load for 4 cycles
        do_rst();
        issue(7, 1, 0, 0);
        issue(9, 0, 0, 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            nop(0);
            if (o_freeze) cnt++;
        end
        chk("freeze_len", cnt, 4);
        step(1, 9, 0, 1, 0, 10, 1, 0, 0, 1, 0);
        chk("freeze_released", o_freeze, 0);
        chk("ex_held_after_freeze", o_stall, EXP_HOLD_STALL);

        // taken branch while ID depends on EX
        do_rst();
        issue(5, 0, 1, 2);
        step(1, 5, 1, 1, 1, 6, 1, 0, 1, 1, 0);
        chk("br_flush", o_flush, 1);
        chk("br_bubble", o_bubble, 1);
        chk("br_no_stall", o_stall, 0);
        step(1, 6, 0, 1, 0, 11, 1, 0, 0, 1, 0);
        chk("br_squashed_never_in_ex", o_stall, 0);

        // writes to x0 never create a hazard
        do_rst();
        issue(0, 0, 1, 2);
        issue(0, 1, 0, 0);
        chk("x0_no_stall", o_stall, 0);
        issue(3, 0, 0, 0);
        chk("x0_ld_no_stall", o_stall, 0);

        // reset during a freeze drops everything
        do_rst();
        issue(7, 1, 0, 0);
        nop(0);
        nop(0);
        chk("pre_rst_freeze", o_freeze, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 0);
        chk("post_rst_stall", o_stall, 0);
        chk("post_rst_freeze", o_freeze, 0);
        chk("post_rst_bubble", o_bubble, 0);
        chk("post_rst_flush", o_flush, 0);
        chk("post_rst_cnt", stall_cycles, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
